// File: rtl/serial_cascade_comparator.sv
// Nibble-serial unsigned magnitude comparator with cascade inputs, processed LSB nibble first.
// Result and done arrive WIDTH/4 cycles after the start is accepted; start is ignored while busy.
module serial_cascade_comparator #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cas_lt,
    input  logic             cas_gt,
    input  logic             cas_eq,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_slt;
    logic             r_sgt;
    logic             r_seq;
    logic [IW-1:0]    r_idx;
    logic             r_done;
    logic             r_lt;
    logic             r_gt;
    logic             r_eq;

    logic             w_accept;
    logic             w_last;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic             w_nlt;
    logic             w_ngt;
    logic             w_neq;

    // Operands shift right each RUN cycle, so the current nibble is always in the low bits.
    assign w_a_nib = r_a[3:0];
    assign w_b_nib = r_b[3:0];
    assign w_last  = (r_idx == IW'(NIB - 1));

    always_comb begin
        w_nlt = r_slt;
        w_ngt = r_sgt;
        w_neq = r_seq;
        if (w_a_nib > w_b_nib) begin
            w_nlt = 1'b0;
            w_ngt = 1'b1;
            w_neq = 1'b0;
        end else if (w_a_nib < w_b_nib) begin
            w_nlt = 1'b1;
            w_ngt = 1'b0;
            w_neq = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == RUN);
        w_accept = (r_state == IDLE) && start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_slt <= 1'b0;
            r_sgt <= 1'b0;
            r_seq <= 1'b0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_a   <= A;
            r_b   <= B;
            r_slt <= cas_lt;
            r_sgt <= cas_gt;
            r_seq <= cas_eq;
            r_idx <= '0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 4;
            r_b   <= r_b >> 4;
            r_slt <= w_nlt;
            r_sgt <= w_ngt;
            r_seq <= w_neq;
            r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
    end

    // Results hold their value between compares; only the final nibble edge updates them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_lt   <= 1'b0;
            r_gt   <= 1'b0;
            r_eq   <= 1'b0;
        end else begin
            r_done <= (r_state == RUN) && w_last;
            if ((r_state == RUN) && w_last) begin
                r_lt <= w_nlt;
                r_gt <= w_ngt;
                r_eq <= w_neq;
            end
        end
    end

    assign done = r_done;
    assign lt   = r_lt;
    assign gt   = r_gt;
    assign eq   = r_eq;

endmodule
